// File: rtl/dac_spi_driver_pkg.sv
// Shared types and constants for the MCP4901-class SPI DAC driver.
// Frame layout: [15:12] config bits, [11:4] sample, [3:0] don't-care zeros.
package dac_spi_driver_pkg;

    localparam int FRAME_WIDTH     = 16;
    localparam int DAC_WIDTH       = 8;
    localparam int DATA_LSB        = 4;
    localparam int DEFAULT_CLK_DIV = 2;

    localparam int A_B_BIT  = 15;
    localparam int BUF_BIT  = 14;
    localparam int GA_BIT   = 13;
    localparam int SHDN_BIT = 12;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        CSHOLD,
        LDAC
    } dacState_t;

    // cfg is ordered {A/B, BUF, GA, SHDN}, matching the top nibble of the frame.
    function automatic logic [FRAME_WIDTH-1:0] buildFrame(
        input logic [3:0]           cfg,
        input logic [DAC_WIDTH-1:0] level
    );
        logic [FRAME_WIDTH-1:0] frame;
        frame                       = '0;
        frame[A_B_BIT]              = cfg[3];
        frame[BUF_BIT]              = cfg[2];
        frame[GA_BIT]               = cfg[1];
        frame[SHDN_BIT]             = cfg[0];
        frame[DATA_LSB +: DAC_WIDTH] = level;
        return frame;
    endfunction

endpackage

// File: rtl/dac_spi_driver_if.sv
// Sample handshake plus DAC pin bundle between generator, driver and board pins.
interface dac_spi_driver_if;

    logic                                  enable;
    logic [dac_spi_driver_pkg::DAC_WIDTH-1:0] dacLevel;
    logic                                  busy;
    logic                                  frameDone;
    logic                                  csN;
    logic                                  sclk;
    logic                                  mosi;
    logic                                  ldacN;

    modport master (
        output enable, dacLevel,
        input  busy, frameDone, csN, sclk, mosi, ldacN
    );

    modport slave (
        input  enable, dacLevel,
        output busy, frameDone, csN, sclk, mosi, ldacN
    );

endinterface

// File: rtl/dac_spi_driver_spi_tick_gen.sv
// Divide counter producing a one-cycle tick every DIV clocks; clear restarts the count.
module spi_tick_gen
    import dac_spi_driver_pkg::*;
#(
    parameter int DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int              W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]    LAST = W'(DIV - 1);

    logic [W-1:0] divCnt;

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    assign tick = (divCnt == LAST);

endmodule

// File: rtl/dac_spi_driver.sv
// Ships one 8-bit sample per frame to an SPI DAC (mode 0, MSB first), then pulses LDAC.
// All pins are registered so the board sees glitch-free chip select and strobe.
module dac_spi_driver
    import dac_spi_driver_pkg::*;
#(
    parameter int         CLK_DIV     = DEFAULT_CLK_DIV,
    parameter logic [3:0] CONFIG_BITS = 4'b0011
) (
    input logic             clk,
    input logic             rst,
    dac_spi_driver_if.slave bus
);

    dacState_t              state, stateNext;
    logic [FRAME_WIDTH-1:0] shiftReg, shiftRegNext;
    logic [4:0]             bitCnt, bitCntNext;
    logic                   sclkReg, sclkNext;
    logic                   csNReg, csNNext;
    logic                   ldacNReg, ldacNNext;
    logic                   mosiReg, mosiNext;
    logic                   busyReg, busyNext;
    logic                   frameDoneReg, frameDoneNext;
    logic                   tick;
    logic                   stateChange;

    assign stateChange = (stateNext != state);

    spi_tick_gen #(
        .DIV (CLK_DIV)
    ) tickGen (
        .clk   (clk),
        .rst   (rst),
        .clear (stateChange),
        .tick  (tick)
    );

    always_comb begin
        stateNext     = state;
        shiftRegNext  = shiftReg;
        bitCntNext    = bitCnt;
        sclkNext      = sclkReg;
        frameDoneNext = 1'b0;

        case (state)
            IDLE: begin
                sclkNext   = 1'b0;
                bitCntNext = '0;
                if (bus.enable) begin
                    shiftRegNext = buildFrame(CONFIG_BITS, bus.dacLevel);
                    stateNext    = SETUP;
                end
            end
            SETUP: begin
                sclkNext = 1'b0;
                if (tick) begin
                    sclkNext  = 1'b1;
                    stateNext = SHIFT;
                end
            end
            // Shift happens on the falling toggle so mosi is settled a full half-period before each rise.
            SHIFT: begin
                if (tick) begin
                    if (sclkReg) begin
                        sclkNext     = 1'b0;
                        shiftRegNext = {shiftReg[FRAME_WIDTH-2:0], 1'b0};
                        bitCntNext   = bitCnt + 5'd1;
                    end else if (bitCnt == 5'(FRAME_WIDTH)) begin
                        stateNext = CSHOLD;
                    end else begin
                        sclkNext = 1'b1;
                    end
                end
            end
            CSHOLD: begin
                sclkNext = 1'b0;
                if (tick) begin
                    stateNext = LDAC;
                end
            end
            LDAC: begin
                sclkNext = 1'b0;
                if (tick) begin
                    stateNext     = IDLE;
                    frameDoneNext = 1'b1;
                end
            end
            default: begin
                sclkNext  = 1'b0;
                stateNext = IDLE;
            end
        endcase

        csNNext   = !(stateNext inside {SETUP, SHIFT, CSHOLD});
        ldacNNext = (stateNext != LDAC);
        busyNext  = (stateNext != IDLE);
        mosiNext  = (stateNext == IDLE) ? 1'b0 : shiftRegNext[FRAME_WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shiftReg     <= '0;
            bitCnt       <= '0;
            sclkReg      <= 1'b0;
            csNReg       <= 1'b1;
            ldacNReg     <= 1'b1;
            mosiReg      <= 1'b0;
            busyReg      <= 1'b0;
            frameDoneReg <= 1'b0;
        end else begin
            state        <= stateNext;
            shiftReg     <= shiftRegNext;
            bitCnt       <= bitCntNext;
            sclkReg      <= sclkNext;
            csNReg       <= csNNext;
            ldacNReg     <= ldacNNext;
            mosiReg      <= mosiNext;
            busyReg      <= busyNext;
            frameDoneReg <= frameDoneNext;
        end
    end

    assign bus.sclk      = sclkReg;
    assign bus.csN       = csNReg;
    assign bus.ldacN     = ldacNReg;
    assign bus.mosi      = mosiReg;
    assign bus.busy      = busyReg;
    assign bus.frameDone = frameDoneReg;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Directed bench for dac_spi_driver: a CLK_DIV=2 instance with a pin-level SPI slave
// monitor, plus a CLK_DIV=1 instance for the fast-clock case.
module tb_dac_spi_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    dac_spi_driver_if bus0 ();
    dac_spi_driver_if bus1 ();

    dac_spi_driver #(.CLK_DIV(2), .CONFIG_BITS(4'b0011)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    dac_spi_driver #(.CLK_DIV(1), .CONFIG_BITS(4'b0011)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    // SPI slave model for dut0: samples 1 time unit after each clk rise and captures mosi on sclk rises.
    logic [15:0] capWord0  = '0;
    logic        prevSclk0 = 1'b0;
    int          riseAny0  = 0;
    int          riseCs0   = 0;
    int          ldacLow0  = 0;
    int          overlap0  = 0;

    always @(posedge clk) begin
        #1;
        if (bus0.sclk === 1'b1 && prevSclk0 === 1'b0) begin
            riseAny0 = riseAny0 + 1;
            if (bus0.csN === 1'b0) begin
                riseCs0  = riseCs0 + 1;
                capWord0 = {capWord0[14:0], bus0.mosi};
            end
        end
        prevSclk0 = bus0.sclk;
        if (bus0.ldacN === 1'b0) ldacLow0 = ldacLow0 + 1;
        if (bus0.ldacN === 1'b0 && bus0.csN === 1'b0) overlap0 = overlap0 + 1;
    end

    task automatic test_reset();
        int riseStart;
        bus0.enable = 1'b0; bus0.dacLevel = 8'h00;
        bus1.enable = 1'b0; bus1.dacLevel = 8'h00;
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        riseStart = riseAny0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            checks++;
            if ({bus0.csN, bus0.ldacN, bus0.sclk, bus0.mosi, bus0.busy, bus0.frameDone} !== 6'b110000) begin
                errors++;
                $display("[TB] FAIL reset_idle_pins cycle %0d: got %b, expected 110000", n,
                         {bus0.csN, bus0.ldacN, bus0.sclk, bus0.mosi, bus0.busy, bus0.frameDone});
            end
        end
        checks++;
        if (riseAny0 - riseStart !== 0) begin
            errors++;
            $display("[TB] FAIL reset_no_sclk: got %0d rises, expected 0", riseAny0 - riseStart);
        end
    endtask

    task automatic test_single_frame();
        int riseStart, ldacStart, overlapStart, doneAt;
        riseStart = riseCs0; ldacStart = ldacLow0; overlapStart = overlap0; doneAt = -1;
        @(negedge clk);
        bus0.dacLevel = 8'hA5;
        bus0.enable   = 1'b1;
        for (int n = 1; n <= 90; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus0.enable = 1'b0;
                checks++;
                if (bus0.csN !== 1'b0 || bus0.busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL single_start: csN/busy got %b%b, expected 01", bus0.csN, bus0.busy);
                end
            end
            if (n == 2 || n == 3) begin
                checks++;
                if (bus0.sclk !== (n == 3)) begin
                    errors++;
                    $display("[TB] FAIL single_first_rise cycle %0d: sclk got %b, expected %b", n, bus0.sclk, n == 3);
                end
            end
            if (n == 68 || n == 69) begin
                checks++;
                if ({bus0.csN, bus0.ldacN} !== ((n == 68) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("[TB] FAIL single_cs_ldac cycle %0d: csN,ldacN got %b", n, {bus0.csN, bus0.ldacN});
                end
            end
            if (bus0.frameDone === 1'b1) begin
                checks++;
                if (doneAt !== -1) begin
                    errors++;
                    $display("[TB] FAIL single_done_pulse: second frameDone at %0d, expected one pulse", n);
                end
                if (doneAt == -1) doneAt = n;
            end
        end
        checks++;
        if (doneAt !== 71) begin
            errors++;
            $display("[TB] FAIL single_done_time: got %0d, expected 71", doneAt);
        end
        checks++;
        if (capWord0 !== 16'h3A50) begin
            errors++;
            $display("[TB] FAIL single_word: got %h, expected 3a50", capWord0);
        end
        checks++;
        if (riseCs0 - riseStart !== 16) begin
            errors++;
            $display("[TB] FAIL single_rises: got %0d, expected 16", riseCs0 - riseStart);
        end
        checks++;
        if (ldacLow0 - ldacStart !== 2 || overlap0 - overlapStart !== 0) begin
            errors++;
            $display("[TB] FAIL single_ldac: low cycles %0d overlap %0d, expected 2 and 0",
                     ldacLow0 - ldacStart, overlap0 - overlapStart);
        end
        checks++;
        if (bus0.busy !== 1'b0 || bus0.csN !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_idle_after: busy,csN got %b%b, expected 01", bus0.busy, bus0.csN);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expWords [3];
        int frames, riseStart;
        expWords[0] = 16'h3000; expWords[1] = 16'h3FF0; expWords[2] = 16'h3800;
        frames = 0;
        riseStart = riseCs0;
        @(negedge clk);
        bus0.dacLevel = 8'h00;
        bus0.enable   = 1'b1;
        for (int n = 1; n <= 240; n++) begin
            @(negedge clk);
            if (n == 30)  bus0.dacLevel = 8'hFF;
            if (n == 100) bus0.dacLevel = 8'h80;
            if (n == 170) begin
                bus0.dacLevel = 8'h55;
                bus0.enable   = 1'b0;
            end
            if (bus0.frameDone === 1'b1) begin
                checks++;
                if (frames >= 3 || n !== 71 * (frames + 1)) begin
                    errors++;
                    $display("[TB] FAIL b2b_done_time: frame %0d done at %0d, expected %0d", frames, n, 71 * (frames + 1));
                end else begin
                    checks++;
                    if (capWord0 !== expWords[frames] || riseCs0 - riseStart !== 16) begin
                        errors++;
                        $display("[TB] FAIL b2b_word %0d: got %h (%0d rises), expected %h (16 rises)",
                                 frames, capWord0, riseCs0 - riseStart, expWords[frames]);
                    end
                end
                frames++;
                riseStart = riseCs0;
            end
        end
        checks++;
        if (frames !== 3 || bus0.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_stop: frames %0d busy %b, expected 3 and 0", frames, bus0.busy);
        end
    endtask

    task automatic test_square_source();
        int frames, overlapStart;
        frames = 0;
        overlapStart = overlap0;
        @(negedge clk);
        bus0.dacLevel = 8'h00;
        bus0.enable   = 1'b1;
        for (int n = 1; n <= 400 && frames < 4; n++) begin
            @(negedge clk);
            if (n % 40 == 0) bus0.dacLevel = ~bus0.dacLevel;
            if (bus0.frameDone === 1'b1) begin
                frames++;
                if (frames == 4) bus0.enable = 1'b0;
                checks++;
                if (capWord0 !== 16'h3000 && capWord0 !== 16'h3FF0) begin
                    errors++;
                    $display("[TB] FAIL square_word %0d: got %h, expected 3000 or 3ff0", frames, capWord0);
                end
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (frames !== 4 || overlap0 - overlapStart !== 0 || bus0.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL square_summary: frames %0d overlap %0d busy %b, expected 4, 0, 0",
                     frames, overlap0 - overlapStart, bus0.busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int ldacStart, riseStart, doneAt;
        ldacStart = ldacLow0;
        @(negedge clk);
        bus0.dacLevel = 8'hC3;
        bus0.enable   = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            @(negedge clk);
            if (n == 1) bus0.enable = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus0.csN, bus0.ldacN, bus0.sclk, bus0.mosi, bus0.busy, bus0.frameDone} !== 6'b110000) begin
            errors++;
            $display("[TB] FAIL abort_pins: got %b, expected 110000",
                     {bus0.csN, bus0.ldacN, bus0.sclk, bus0.mosi, bus0.busy, bus0.frameDone});
        end
        checks++;
        if (ldacLow0 - ldacStart !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_ldac: got %0d low cycles, expected 0", ldacLow0 - ldacStart);
        end
        rst = 1'b0;
        bus0.dacLevel = 8'h3C;
        bus0.enable   = 1'b1;
        riseStart = riseCs0; ldacStart = ldacLow0; doneAt = -1;
        for (int n = 1; n <= 80 && doneAt == -1; n++) begin
            @(negedge clk);
            if (n == 1) bus0.enable = 1'b0;
            if (bus0.frameDone === 1'b1) doneAt = n;
        end
        checks++;
        if (doneAt !== 71 || capWord0 !== 16'h33C0) begin
            errors++;
            $display("[TB] FAIL abort_recover: done at %0d word %h, expected 71 and 33c0", doneAt, capWord0);
        end
        checks++;
        if (riseCs0 - riseStart !== 16 || ldacLow0 - ldacStart !== 2) begin
            errors++;
            $display("[TB] FAIL abort_recover_shape: rises %0d ldac %0d, expected 16 and 2",
                     riseCs0 - riseStart, ldacLow0 - ldacStart);
        end
    endtask

    task automatic test_clk_div1();
        logic [15:0] word;
        logic        prevS;
        int          frames, rises, firstRise, lastRise;
        word = '0; frames = 0; rises = 0; firstRise = -1; lastRise = -1;
        @(negedge clk);
        bus1.dacLevel = 8'h5A;
        bus1.enable   = 1'b1;
        prevS = bus1.sclk;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 40) bus1.enable = 1'b0;
            if (bus1.sclk === 1'b1 && prevS === 1'b0 && bus1.csN === 1'b0) begin
                word  = {word[14:0], bus1.mosi};
                rises++;
                if (firstRise < 0) firstRise = n - 36 * frames;
                lastRise = n - 36 * frames;
            end
            prevS = bus1.sclk;
            if (bus1.frameDone === 1'b1) begin
                checks++;
                if (n !== 36 * (frames + 1) || word !== 16'h35A0) begin
                    errors++;
                    $display("[TB] FAIL div1_frame %0d: done at %0d word %h, expected %0d and 35a0",
                             frames, n, word, 36 * (frames + 1));
                end
                checks++;
                if (rises !== 16 || firstRise !== 2 || lastRise !== 32) begin
                    errors++;
                    $display("[TB] FAIL div1_sclk %0d: rises %0d first %0d last %0d, expected 16, 2, 32",
                             frames, rises, firstRise, lastRise);
                end
                frames++;
                rises = 0; firstRise = -1; lastRise = -1;
            end
        end
        checks++;
        if (frames !== 2 || bus1.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div1_stop: frames %0d busy %b, expected 2 and 0", frames, bus1.busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_square_source();
        test_reset_mid_frame();
        test_clk_div1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
